pending_req_encoder: RTL and testbench

- Parametrised, registered priority encoder for N request lines, successor to the combinational 16-to-4 encoder.
- Request pulses are captured into a sticky pending register.
- The block issues pending indices one at a time over a valid/ready handshake and clears each index as it issues.
- Arbitration is either fixed priority (highest index wins) or round-robin.
- Sits between interrupt/event sources and a single consumer, such as a sequencer or an interrupt handler FSM.

---
 rtl/pending_req_encoder.sv | 101 ++++++++++
 tb/tb_pending_req_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pending_req_encoder.sv
// Registered priority encoder: captures request pulses into a sticky pending
// register and issues pending indices one at a time over a valid/ready handshake.
module pending_req_encoder #(
    parameter int N    = 16,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         clr,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   pend_cnt,
    output logic         any_pend,
    output logic         dropped
);

    logic [N-1:0] pending;
    logic [N-1:0] issue_mask;
    logic [N-1:0] next_pending;
    logic [W:0]   next_cnt;
    logic [W-1:0] last;
    logic [W-1:0] sel;
    logic [W-1:0] sel_hi;
    logic [W-1:0] sel_lo;
    logic         hit_hi;
    logic         load;
    int unsigned  start;

    always_comb begin
        sel    = '0;
        sel_hi = '0;
        sel_lo = '0;
        hit_hi = 1'b0;
        start  = 0;
        if (MODE == 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (pending[i]) sel = W'(i);
            end
        end else begin
            start = (32'(last) + 1 >= N) ? 0 : 32'(last) + 1;
            // Descending scan keeps the lowest set bit overall (wrap case) and the
            // lowest set bit at or above the start point (no-wrap case).
            for (int unsigned i = N; i > 0; i--) begin
                if (pending[i-1]) begin
                    sel_lo = W'(i - 1);
                    if (i - 1 >= start) begin
                        sel_hi = W'(i - 1);
                        hit_hi = 1'b1;
                    end
                end
            end
            sel = hit_hi ? sel_hi : sel_lo;
        end
    end

    assign load         = (!out_valid || out_ready) && (pending != '0);
    assign issue_mask   = load ? (N'(1) << sel) : '0;
    assign next_pending = (pending & ~issue_mask) | req;

    always_comb begin
        next_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            next_cnt = next_cnt + {{W{1'b0}}, next_pending[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            pend_cnt  <= '0;
            any_pend  <= 1'b0;
            dropped   <= 1'b0;
            last      <= W'(N - 1);
        end else if (clr) begin
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            pend_cnt  <= '0;
            any_pend  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            pending  <= next_pending;
            pend_cnt <= next_cnt;
            any_pend <= |next_pending;
            dropped  <= |(req & pending & ~issue_mask);
            if (load) begin
                out_idx   <= sel;
                out_valid <= 1'b1;
                if (MODE == 1) last <= sel;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pending_req_encoder.sv
// Directed bench: fixed-priority instance (N=16) and round-robin instance (N=10).
module tb_pending_req_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] req0 = '0;
    logic        clr0 = 1'b0;
    logic        ready0 = 1'b0;
    logic [3:0]  idx0;
    logic        valid0;
    logic [4:0]  cnt0;
    logic        any0;
    logic        drop0;

    logic [9:0]  req1 = '0;
    logic        clr1 = 1'b0;
    logic        ready1 = 1'b0;
    logic [3:0]  idx1;
    logic        valid1;
    logic [4:0]  cnt1;
    logic        any1;
    logic        drop1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pending_req_encoder #(.N(16), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .clr(clr0),
        .out_idx(idx0), .out_valid(valid0), .out_ready(ready0),
        .pend_cnt(cnt0), .any_pend(any0), .dropped(drop0)
    );

    pending_req_encoder #(.N(10), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .clr(clr1),
        .out_idx(idx1), .out_valid(valid1), .out_ready(ready1),
        .pend_cnt(cnt1), .any_pend(any1), .dropped(drop1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with all requests asserted
        req0 = 16'hFFFF;
        req1 = 10'h3FF;
        tick();
        tick();
        chk("rst_valid0", 32'(valid0), 0);
        chk("rst_idx0", 32'(idx0), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_any0", 32'(any0), 0);
        chk("rst_drop0", 32'(drop0), 0);
        chk("rst_valid1", 32'(valid1), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        rst = 1'b0;
        req0 = '0;
        req1 = '0;
        tick();
        chk("idle_valid0", 32'(valid0), 0);
        chk("idle_any0", 32'(any0), 0);
        chk("idle_valid1", 32'(valid1), 0);

        // fixed priority: 0x8421 -> 15,10,5,0
        ready0 = 1'b1;
        req0 = 16'h8421;
        tick();
        chk("fp_lat_valid", 32'(valid0), 0);
        chk("fp_cnt4", 32'(cnt0), 4);
        chk("fp_any", 32'(any0), 1);
        req0 = '0;
        tick();
        chk("fp_valid", 32'(valid0), 1);
        chk("fp_idx15", 32'(idx0), 15);
        chk("fp_cnt3", 32'(cnt0), 3);
        tick();
        chk("fp_idx10", 32'(idx0), 10);
        chk("fp_cnt2", 32'(cnt0), 2);
        tick();
        chk("fp_idx5", 32'(idx0), 5);
        chk("fp_cnt1", 32'(cnt0), 1);
        tick();
        chk("fp_idx0", 32'(idx0), 0);
        chk("fp_cnt0", 32'(cnt0), 0);
        chk("fp_any_end", 32'(any0), 0);
        chk("fp_valid_still", 32'(valid0), 1);
        tick();
        chk("fp_drain_valid", 32'(valid0), 0);
        chk("fp_drain_idx", 32'(idx0), 0);

        // backpressure: idx 7 held while bit 3 arrives
        ready0 = 1'b0;
        req0 = 16'h0080;
        tick();
        req0 = '0;
        tick();
        chk("bp_valid", 32'(valid0), 1);
        chk("bp_idx7", 32'(idx0), 7);
        req0 = 16'h0008;
        tick();
        req0 = '0;
        chk("bp_hold_a", 32'(idx0), 7);
        chk("bp_cnt1", 32'(cnt0), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("bp_hold_b", 32'(idx0), 7);
        chk("bp_hold_valid", 32'(valid0), 1);
        ready0 = 1'b1;
        tick();
        chk("bp_next_idx3", 32'(idx0), 3);
        chk("bp_next_valid", 32'(valid0), 1);
        chk("bp_next_cnt", 32'(cnt0), 0);
        tick();
        chk("bp_drain_valid", 32'(valid0), 0);

        // drop and re-arm on bit 4
        ready0 = 1'b0;
        req0 = 16'h0002;
        tick();
        req0 = '0;
        tick();
        chk("dr_occupy_idx1", 32'(idx0), 1);
        req0 = 16'h0010;
        tick();
        chk("dr_first_nodrop", 32'(drop0), 0);
        chk("dr_cnt1", 32'(cnt0), 1);
        tick();
        chk("dr_drop", 32'(drop0), 1);
        chk("dr_cnt_same", 32'(cnt0), 1);
        req0 = '0;
        tick();
        chk("dr_pulse_end", 32'(drop0), 0);
        ready0 = 1'b1;
        req0 = 16'h0010;
        tick();
        req0 = '0;
        chk("rearm_nodrop", 32'(drop0), 0);
        chk("rearm_idx4", 32'(idx0), 4);
        chk("rearm_cnt1", 32'(cnt0), 1);
        tick();
        chk("rearm_again_idx4", 32'(idx0), 4);
        chk("rearm_again_valid", 32'(valid0), 1);
        chk("rearm_cnt0", 32'(cnt0), 0);
        tick();
        chk("rearm_drain", 32'(valid0), 0);

        // clr with 3 pending, output occupied, and a same-cycle request
        ready0 = 1'b0;
        req0 = 16'h0F00;
        tick();
        req0 = '0;
        tick();
        chk("clr_pre_idx11", 32'(idx0), 11);
        chk("clr_pre_cnt3", 32'(cnt0), 3);
        clr0 = 1'b1;
        req0 = 16'h0002;
        tick();
        clr0 = 1'b0;
        req0 = '0;
        chk("clr_valid", 32'(valid0), 0);
        chk("clr_cnt", 32'(cnt0), 0);
        chk("clr_any", 32'(any0), 0);
        chk("clr_idx", 32'(idx0), 0);
        chk("clr_drop", 32'(drop0), 0);
        ready0 = 1'b1;
        tick();
        chk("clr_no_capture_valid", 32'(valid0), 0);
        chk("clr_no_capture_cnt", 32'(cnt0), 0);

        // round-robin N=10: {9,2,0} -> 0,2,9; then {0,9} -> 0,9
        ready1 = 1'b1;
        req1 = 10'h205;
        tick();
        chk("rr_cnt3", 32'(cnt1), 3);
        chk("rr_lat_valid", 32'(valid1), 0);
        req1 = '0;
        tick();
        chk("rr_idx0", 32'(idx1), 0);
        chk("rr_valid", 32'(valid1), 1);
        tick();
        chk("rr_idx2", 32'(idx1), 2);
        tick();
        chk("rr_idx9", 32'(idx1), 9);
        chk("rr_cnt0", 32'(cnt1), 0);
        tick();
        chk("rr_drain", 32'(valid1), 0);
        req1 = 10'h201;
        tick();
        req1 = '0;
        tick();
        chk("rr_wrap_idx0", 32'(idx1), 0);
        tick();
        chk("rr_wrap_idx9", 32'(idx1), 9);
        tick();
        chk("rr_wrap_drain", 32'(valid1), 0);

        // round-robin fairness: last=9, {5,3} -> 3 then 5 even with more pending
        req1 = 10'h028;
        tick();
        req1 = '0;
        tick();
        chk("rr_fair_idx3", 32'(idx1), 3);
        req1 = 10'h001;
        tick();
        req1 = '0;
        chk("rr_fair_idx5", 32'(idx1), 5);
        tick();
        chk("rr_fair_wrap_idx0", 32'(idx1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
